// File: rtl/aes256_key_store.sv
// AES-256 key expansion store: 15 round keys, two per clock.
// Registered read port with encryption/decryption ordering.
module aes256_key_store (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rd_inv,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [2:0]   r_step;
  logic [31:0]  r_w [8];
  logic [31:0]  w_n [8];
  logic [127:0] r_store [15];
  logic [127:0] r_rk_out;
  logic         w_accept;
  logic [7:0]   w_rcon;
  logic [31:0]  w_rot;
  logic [3:0]   w_p;

  function automatic logic [7:0] f_gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254, then the FIPS-197 affine map.
  function automatic logic [7:0] f_sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = f_gmul(sq, sq);
      r  = f_gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [31:0] f_subword(
    input logic [31:0] w
  );
    return {f_sbox(w[31:24]), f_sbox(w[23:16]),
            f_sbox(w[15:8]),  f_sbox(w[7:0])};
  endfunction

  assign w_rot  = {r_w[7][23:0], r_w[7][31:24]};
  assign w_rcon = 8'h01 << (r_step - 3'd1);

  always_comb begin
    w_n[0] = r_w[0] ^ f_subword(w_rot) ^ {w_rcon, 24'h0};
    w_n[1] = r_w[1] ^ w_n[0];
    w_n[2] = r_w[2] ^ w_n[1];
    w_n[3] = r_w[3] ^ w_n[2];
    w_n[4] = r_w[4] ^ f_subword(w_n[3]);
    w_n[5] = r_w[5] ^ w_n[4];
    w_n[6] = r_w[6] ^ w_n[5];
    w_n[7] = r_w[7] ^ w_n[6];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    key_ready  = 1'b1;
    busy       = 1'b0;
    keys_valid = 1'b0;
    w_accept   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_accept = key_valid;
        if (key_valid) w_next = S_EXPAND;
      end
      S_EXPAND: begin
        key_ready = 1'b0;
        busy      = 1'b1;
        if (r_step == 3'd7) w_next = S_READY;
      end
      S_READY: begin
        keys_valid = 1'b1;
        w_accept   = key_valid;
        if (key_valid) w_next = S_EXPAND;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
      for (int i = 0; i < 8; i++) r_w[i] <= '0;
    end else if (w_accept) begin
      r_step <= 3'd1;
      for (int i = 0; i < 8; i++)
        r_w[i] <= key[255-32*i -: 32];
    end else if (r_state == S_EXPAND) begin
      r_step <= (r_step == 3'd7) ? 3'd0 : r_step + 3'd1;
      for (int i = 0; i < 8; i++) r_w[i] <= w_n[i];
    end
  end

  // The key store itself is never reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_store[0] <= key[255:128];
      r_store[1] <= key[127:0];
    end else if (r_state == S_EXPAND) begin
      r_store[{r_step, 1'b0}] <=
        {w_n[0], w_n[1], w_n[2], w_n[3]};
      if (r_step != 3'd7)
        r_store[{r_step, 1'b1}] <=
          {w_n[4], w_n[5], w_n[6], w_n[7]};
    end
  end

  assign w_p = rd_inv ? (4'd14 - rk_idx) : rk_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_rk_out <= '0;
    else if (rk_idx == 4'hf) r_rk_out <= '0;
    else                     r_rk_out <= r_store[w_p];
  end

  assign rk_out = r_rk_out;

endmodule
